// File: rtl/mic_pkg.sv
// mic_pkg: constants and encodings shared by the mic frame buffer blocks
// (mic_frame_reader, mic_data_store).
//   MIC_ADDR_W     frame buffer address width (depth = 2**MIC_ADDR_W)
//   MIC_DATA_W     signed sample width
//   mic_rd_state_e read-side controller state encoding
package mic_pkg;

  localparam int MIC_ADDR_W = 10;
  localparam int MIC_DATA_W = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } mic_rd_state_e;

endpackage

// File: rtl/mic_frame_reader_if.sv
// mic_frame_reader_if: valid/ready sample stream from the frame reader to the
// cross-correlation engine.
//   m_valid  sample valid              (master -> slave)
//   m_ready  downstream accept         (slave  -> master)
//   m_data   signed sample             (master -> slave)
//   m_last   last sample of the burst  (master -> slave)
interface mic_frame_reader_if #(
  parameter int DATA_W = 18
);

  logic                     m_valid;
  logic                     m_ready;
  logic signed [DATA_W-1:0] m_data;
  logic                     m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/mic_skid_buf.sv
// mic_skid_buf: 2-entry valid/ready buffer. The writer never pushes into a
// full buffer (slots are reserved before the RAM read is issued), so there is
// no input ready. Output data is forced to 0 while empty.
//   clk, rst_n   clock, async active-low reset
//   in_valid_i   push in_data_i this cycle
//   in_data_i    entry to store
//   out_valid_o  head entry valid
//   out_ready_i  consumer accepts head
//   out_data_o   head entry
//   occ_o        current occupancy, 0..2
module mic_skid_buf #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   occ_o
);

  logic [W-1:0] mem_q [2];
  logic         wptr_q;
  logic         rptr_q;
  logic [1:0]   cnt_q;
  logic         pop;

  assign out_valid_o = (cnt_q != 2'd0);
  assign pop         = out_valid_o & out_ready_i;
  assign out_data_o  = out_valid_o ? mem_q[rptr_q] : '0;
  assign occ_o       = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (in_valid_i) begin
        mem_q[wptr_q] <= in_data_i;
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, in_valid_i} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/mic_frame_reader.sv
// mic_frame_reader: read-side controller for the mic sample frame buffer.
// Waits for the store side to finish a frame, then streams FRAME_LEN samples
// from rd_base (wrapping modulo 2**ADDR_W) out of the buffer's port B into a
// valid/ready stream. A 2-entry skid buffer absorbs the RAM read latency.
//   clk, rst_n        clock, async active-low reset
//   store_busy        store side writing a frame
//   rd_req, rd_base   burst request pulse and start address
//   rd_en, rd_addr    buffer port-B enable/address
//   rd_data           buffer port-B data, RD_LAT cycles after rd_en
//   m                 output sample stream (master)
//   busy, done        burst active / 1-cycle completion pulse
//   overrun           sticky: store_busy rose during the burst
module mic_frame_reader
  import mic_pkg::*;
#(
  parameter int ADDR_W    = MIC_ADDR_W,
  parameter int DATA_W    = MIC_DATA_W,
  parameter int FRAME_LEN = 1024,
  parameter int RD_LAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     store_busy,
  input  logic                     rd_req,
  input  logic [ADDR_W-1:0]        rd_base,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [DATA_W-1:0] rd_data,
  mic_frame_reader_if.master       m,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  mic_rd_state_e     state_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  issue_cnt_q;
  logic              busy_q, done_q, overrun_q;
  logic              pend_q, sb_prev_q;

  // Stage 0 is the read being issued this cycle; stage RD_LAT lines up with
  // valid rd_data and pushes into the skid buffer.
  logic [RD_LAT:1]   vld_pipe_q, last_pipe_q;
  logic [RD_LAT:0]   vld_pipe, last_pipe;

  logic              accept, issue, pop, is_last_issue;
  logic              sb_fall, sb_rise;
  logic [1:0]        infl;
  logic [2:0]        slots_used;
  logic [1:0]        skid_occ;
  logic [DATA_W:0]   skid_head;

  assign sb_fall       = sb_prev_q & ~store_busy;
  assign sb_rise       = ~sb_prev_q & store_busy;
  assign accept        = (state_q == ST_IDLE) & rd_req & pend_q & ~store_busy;
  assign pop           = m.m_valid & m.m_ready;
  assign is_last_issue = (issue_cnt_q == LAST_IDX);

  always_comb begin
    infl = 2'd0;
    for (int i = 1; i <= RD_LAT; i++) infl = infl + 2'(vld_pipe_q[i]);
  end

  // Skid slots are reserved at issue time. A sample leaving this cycle frees
  // its slot, which keeps the stream at 1 sample/cycle with RD_LAT = 1.
  assign slots_used = 3'(skid_occ) + 3'(infl);
  assign issue      = (state_q == ST_READ) & (slots_used < (3'd2 + 3'(pop)));

  assign vld_pipe  = {vld_pipe_q, issue};
  assign last_pipe = {last_pipe_q, issue & is_last_issue};

  assign rd_en   = issue;
  assign rd_addr = base_q + issue_cnt_q[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe[RD_LAT-1:0];
      last_pipe_q <= last_pipe[RD_LAT-1:0];
    end
  end

  mic_skid_buf #(.W(DATA_W + 1)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (vld_pipe_q[RD_LAT]),
    .in_data_i   ({last_pipe_q[RD_LAT], rd_data}),
    .out_valid_o (m.m_valid),
    .out_ready_i (m.m_ready),
    .out_data_o  (skid_head),
    .occ_o       (skid_occ)
  );

  assign m.m_data = skid_head[DATA_W-1:0];
  assign m.m_last = skid_head[DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      pend_q      <= 1'b0;
      sb_prev_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      sb_prev_q <= store_busy;
      // A frame finishing in the same cycle a burst starts stays pending.
      if (sb_fall)     pend_q <= 1'b1;
      else if (accept) pend_q <= 1'b0;
      if (busy_q && sb_rise) overrun_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q     <= ST_READ;
            base_q      <= rd_base;
            issue_cnt_q <= '0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ST_READ: begin
          if (issue) begin
            issue_cnt_q <= issue_cnt_q + 1'b1;
            if (is_last_issue) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The tagged last sample leaving the skid implies nothing remains
          // in flight or buffered.
          if (pop && m.m_last) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_mic_frame_reader.sv
// Directed bench for mic_frame_reader: full-frame bursts, address wrap,
// backpressure, ignored requests, overrun, mid-burst reset, and a
// FRAME_LEN = 1 instance.
module tb_mic_frame_reader;

  localparam int AW = 10;
  localparam int DW = 18;
  localparam int FL = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic store_busy = 1'b0;
  logic rd_req = 1'b0;
  logic [AW-1:0] rd_base = '0;
  logic rd_en;
  logic [AW-1:0] rd_addr;
  logic signed [DW-1:0] rd_data = '0;
  logic busy, done, overrun;

  logic sb1 = 1'b0;
  logic rq1 = 1'b0;
  logic [AW-1:0] base1 = '0;
  logic rd_en1;
  logic [AW-1:0] rd_addr1;
  logic signed [DW-1:0] rd_data1 = '0;
  logic busy1, done1, ovr1;

  int n_cmp = 0;
  int n_err = 0;

  mic_frame_reader_if #(.DATA_W(DW)) strm ();
  mic_frame_reader_if #(.DATA_W(DW)) strm1 ();

  mic_frame_reader #(.ADDR_W(AW), .DATA_W(DW), .FRAME_LEN(FL), .RD_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .store_busy(store_busy), .rd_req(rd_req), .rd_base(rd_base),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .m(strm.master),
    .busy(busy), .done(done), .overrun(overrun)
  );

  mic_frame_reader #(.ADDR_W(AW), .DATA_W(DW), .FRAME_LEN(1), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .store_busy(sb1), .rd_req(rq1), .rd_base(base1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1), .m(strm1.master),
    .busy(busy1), .done(done1), .overrun(ovr1)
  );

  always #5 clk = ~clk;

  // Frame buffer content: sample at address a is a*131+7 as 18-bit signed.
  function automatic logic signed [DW-1:0] ram_f(input logic [AW-1:0] a);
    return DW'(32'(a) * 131 + 7);
  endfunction

  always @(posedge clk) begin
    if (rd_en)  rd_data  <= ram_f(rd_addr);
    if (rd_en1) rd_data1 <= ram_f(rd_addr1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_frame();
    @(negedge clk) store_busy = 1'b1;
    repeat (3) @(negedge clk);
    store_busy = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rd_en"},   32'(rd_en),        32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr),      32'd0);
    chk({tag, "_m_valid"}, 32'(strm.m_valid), 32'd0);
    chk({tag, "_m_data"},  32'(strm.m_data),  32'd0);
    chk({tag, "_m_last"},  32'(strm.m_last),  32'd0);
    chk({tag, "_busy"},    32'(busy),         32'd0);
    chk({tag, "_done"},    32'(done),         32'd0);
    chk({tag, "_overrun"}, 32'(overrun),      32'd0);
  endtask

  // One burst from base. rnd: pseudo-random m_ready. dup_at: cycle of an
  // extra rd_req (ignored). ovr_at: cycle store_busy pulses. rst_at: sample
  // index where reset is asserted (-1 for none).
  task automatic burst(input logic [AW-1:0] base, input bit rnd, input int dup_at,
                       input int ovr_at, input int rst_at);
    int k = 0;
    int ai = 0;
    bit stall_prev = 1'b0;
    logic signed [DW-1:0] prev_data = '0;
    logic [AW-1:0] exp_a;
    @(negedge clk);
    rd_req = 1'b1;
    rd_base = base;
    strm.m_ready = 1'b1;
    for (int cyc = 0; cyc < 4 * FL + 20 && k < FL; cyc++) begin
      @(negedge clk);
      if (cyc == 0) rd_req = 1'b0;
      if (cyc == dup_at) begin rd_req = 1'b1; rd_base = base + 10'd300; end
      else if (cyc == dup_at + 1) rd_req = 1'b0;
      if (ovr_at >= 0) store_busy = (cyc >= ovr_at && cyc < ovr_at + 4);
      strm.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (cyc == 0) begin
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_ovr_clr", 32'(overrun), 32'd0);
        chk("lat_valid_c0", 32'(strm.m_valid), 32'd0);
      end
      if (cyc == 1) chk("lat_valid_c1", 32'(strm.m_valid), 32'd0);
      if (cyc == 2) chk("lat_valid_c2", 32'(strm.m_valid), 32'd1);
      if (rst_at >= 0 && k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        @(negedge clk) rst_n = 1'b1;
        return;
      end
      if (rd_en) begin
        exp_a = base + 10'(ai);
        chk("rd_addr", 32'(rd_addr), 32'(exp_a));
        ai++;
      end
      if (stall_prev) begin
        chk("hold_valid", 32'(strm.m_valid), 32'd1);
        chk("hold_data", 32'(strm.m_data), 32'(prev_data));
      end
      chk("occ_le2", 32'(u_dut.skid_occ <= 2'd2), 32'd1);
      if (strm.m_valid && strm.m_ready) begin
        exp_a = base + 10'(k);
        chk("m_data", 32'(strm.m_data), 32'(ram_f(exp_a)));
        chk("m_last", 32'(strm.m_last), 32'(k == FL - 1));
        k++;
      end
      stall_prev = strm.m_valid && !strm.m_ready;
      prev_data = strm.m_data;
    end
    chk("sample_count", 32'(k), 32'(FL));
    @(negedge clk);
    strm.m_ready = 1'b1;
    #1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("issue_count", 32'(ai), 32'(FL));
    chk("overrun_end", 32'(overrun), 32'(ovr_at >= 0));
    @(negedge clk) #1;
    chk("done_low", 32'(done), 32'd0);
    chk("valid_idle", 32'(strm.m_valid), 32'd0);
  endtask

  initial begin
    strm.m_ready = 1'b0;
    strm1.m_ready = 1'b0;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    // Request with no completed frame since reset is ignored.
    @(negedge clk) begin rd_req = 1'b1; rd_base = 10'd5; end
    @(negedge clk) rd_req = 1'b0;
    #1;
    chk("nopend_busy", 32'(busy), 32'd0);
    chk("nopend_rd_en", 32'(rd_en), 32'd0);
    @(negedge clk) #1;
    chk("nopend_valid", 32'(strm.m_valid), 32'd0);

    new_frame(); burst(10'd0,    1'b0, -1, -1, -1);   // full frame from 0
    new_frame(); burst(10'd1020, 1'b0, -1, -1, -1);   // address wrap
    new_frame(); burst(10'd37,   1'b1, 50, -1, -1);   // backpressure + ignored rd_req
    new_frame(); burst(10'd500,  1'b0, -1, 300, -1);  // overrun, burst completes
    new_frame(); burst(10'd200,  1'b1, -1, -1, 500);  // reset mid-burst
    new_frame(); burst(10'd3,    1'b0, -1, -1, -1);   // normal after reset

    // Single-sample burst at the top address.
    @(negedge clk) sb1 = 1'b1;
    @(negedge clk) sb1 = 1'b0;
    @(negedge clk) begin rq1 = 1'b1; base1 = 10'd1023; strm1.m_ready = 1'b1; end
    @(negedge clk) rq1 = 1'b0;
    #1;
    chk("fl1_rd_en", 32'(rd_en1), 32'd1);
    chk("fl1_rd_addr", 32'(rd_addr1), 32'd1023);
    chk("fl1_busy", 32'(busy1), 32'd1);
    @(negedge clk) #1;
    chk("fl1_rd_en_off", 32'(rd_en1), 32'd0);
    chk("fl1_valid_c1", 32'(strm1.m_valid), 32'd0);
    @(negedge clk) #1;
    chk("fl1_valid", 32'(strm1.m_valid), 32'd1);
    chk("fl1_last", 32'(strm1.m_last), 32'd1);
    chk("fl1_data", 32'(strm1.m_data), 32'(ram_f(10'd1023)));
    @(negedge clk) #1;
    chk("fl1_done", 32'(done1), 32'd1);
    chk("fl1_busy_end", 32'(busy1), 32'd0);
    chk("fl1_valid_end", 32'(strm1.m_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
